// File: rtl/data_mem_port.sv
// data_mem_port: load/store responder between the MEM pipeline stage and a
// word-organized synchronous data SRAM with one cycle of read latency.
// Performs lw/lh/lb/sw/sh/sb with little-endian lane selection, sign-extended
// loads and read-modify-write for sub-word stores. Stall holds the pipeline
// until the access completes.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned word/half
// accesses (Misaligned pulse, no SRAM access). Without it, misaligned
// addresses are truncated and Misaligned is tied 0.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   R_Enable, W_Enable    load / store request (store wins if both)
//   R_Width, W_Width      0=word 1=half 2=byte 3=reserved
//   Address, WriteData    byte address, store data (sub-word in low bits)
//   ReadData              registered sign-extended load result
//   Stall                 combinational pipeline hold
//   Done, Misaligned      one-cycle completion / alignment-fault pulses
//   Mem_Addr/RE/WE/WData  SRAM request (registered)
//   Mem_RData             SRAM read word, valid the cycle after Mem_RE
module data_mem_port #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  R_Enable,
    input  logic                  W_Enable,
    input  logic [1:0]            R_Width,
    input  logic [1:0]            W_Width,
    input  logic [31:0]           Address,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  Stall,
    output logic                  Done,
    output logic                  Misaligned,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic                  Mem_RE,
    output logic                  Mem_WE,
    output logic [31:0]           Mem_WData,
    input  logic [31:0]           Mem_RData
);

    localparam logic [1:0] WIDTH_WORD = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_BYTE = 2'd2;
    localparam logic [1:0] WIDTH_RSVD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [1:0]            width_q, width_d;
    logic [1:0]            offset_q, offset_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_re_q, mem_re_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic                  req;
    logic [1:0]            req_width;
    logic                  misalign;

    // Address bits above the SRAM word address are intentionally ignored.
    logic                  unused_addr;
    assign unused_addr = ^Address[31:ADDR_WIDTH+2];

    // Extract the addressed lane from a read word and sign-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  width,
                                                 input logic [1:0]  offset);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
        case (width)
            WIDTH_WORD: res = word;
            WIDTH_HALF: res = {{16{h[15]}}, h};
            WIDTH_BYTE: res = {{24{b[7]}}, b};
            default:    res = 32'd0;
        endcase
        return res;
    endfunction

    // Merge sub-word store data into the word read back from the SRAM.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [1:0]  width,
                                                input logic [1:0]  offset);
        logic [31:0] res;
        res = word;
        case (width)
            WIDTH_WORD: res = data;
            WIDTH_HALF: begin
                if (offset[1]) res[31:16] = data[15:0];
                else           res[15:0]  = data[15:0];
            end
            WIDTH_BYTE: begin
                case (offset)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    default: res[31:24] = data[7:0];
                endcase
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Request decode: a store takes priority over a simultaneous load.
    assign req       = R_Enable | W_Enable;
    assign req_width = W_Enable ? W_Width : R_Width;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_width == WIDTH_WORD) && (Address[1:0] != 2'd0)) ||
                      ((req_width == WIDTH_HALF) && Address[0]);
`else
    assign misalign = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        width_d     = width_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    is_store_d = W_Enable;
                    width_d    = req_width;
                    offset_d   = Address[1:0];
                    wdata_d    = WriteData;
                    mem_addr_d = Address[ADDR_WIDTH+1:2];
                    if (misalign) begin
                        state_d = S_DONE;
                    end else if (req_width == WIDTH_RSVD) begin
                        state_d = S_DONE;
                        if (!W_Enable) read_data_d = 32'd0;
                    end else if (W_Enable && (req_width == WIDTH_WORD)) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = WriteData;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT: begin
                if (is_store_q) begin
                    mem_wdata_d = store_merge(Mem_RData, wdata_q, width_q, offset_q);
                    state_d     = S_WRITE;
                end else begin
                    read_data_d = load_extract(Mem_RData, width_q, offset_q);
                    state_d     = S_DONE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the state being entered.
        mem_re_d = (state_d == S_READ);
        mem_we_d = (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            width_q     <= WIDTH_WORD;
            offset_q    <= 2'd0;
            wdata_q     <= 32'd0;
            read_data_q <= 32'd0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            width_q     <= width_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Fault pulse coincides with the DONE cycle of a trapped request.
    logic misaligned_q;
    always_ff @(posedge Clk) begin
        if (Reset) misaligned_q <= 1'b0;
        else       misaligned_q <= (state_q == S_IDLE) && req && misalign;
    end
    assign Misaligned = misaligned_q;
`else
    assign Misaligned = 1'b0;
`endif

    // Stall is combinational so the request cycle itself is held.
    assign Stall = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE) ||
                   ((state_q == S_IDLE) && req);

    assign ReadData  = read_data_q;
    assign Done      = done_q;
    assign Mem_Addr  = mem_addr_q;
    assign Mem_RE    = mem_re_q;
    assign Mem_WE    = mem_we_q;
    assign Mem_WData = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: behavioural SRAM, scoreboard of expected access
// outcomes, reset-in-flight check and the misaligned-access case.
module tb_data_mem_port;

    localparam int unsigned AW = 10;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          R_Enable, W_Enable;
    logic [1:0]    R_Width, W_Width;
    logic [31:0]   Address, WriteData;
    logic [31:0]   ReadData;
    logic          Stall, Done, Misaligned;
    logic [AW-1:0] Mem_Addr;
    logic          Mem_RE, Mem_WE;
    logic [31:0]   Mem_WData;
    logic [31:0]   Mem_RData;

    data_mem_port #(.ADDR_WIDTH(AW)) dut (
        .Clk(Clk), .Reset(Reset),
        .R_Enable(R_Enable), .W_Enable(W_Enable),
        .R_Width(R_Width), .W_Width(W_Width),
        .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .Done(Done), .Misaligned(Misaligned),
        .Mem_Addr(Mem_Addr), .Mem_RE(Mem_RE), .Mem_WE(Mem_WE),
        .Mem_WData(Mem_WData), .Mem_RData(Mem_RData)
    );

    always #5 Clk = ~Clk;

    // Synchronous SRAM with a bench-side preload port.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          bk_we;
    logic [AW-1:0] bk_addr;
    logic [31:0]   bk_data;
    always @(posedge Clk) begin
        if (Mem_WE)     mem[Mem_Addr] <= Mem_WData;
        else if (bk_we) mem[bk_addr]  <= bk_data;
        if (Mem_RE)     Mem_RData     <= mem[Mem_Addr];
    end

    typedef struct {
        int          done_cyc;
        int          re_cyc;
        int          we_cyc;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int d, input int r, input int w,
                                input logic [31:0] wd, input logic [31:0] rd, input logic mis);
        exp_t e;
        e.done_cyc = d; e.re_cyc = r; e.we_cyc = w;
        e.wdata = wd; e.rdata = rd; e.mis = mis;
        return e;
    endfunction

    task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        @(posedge Clk); #1;
        bk_we = 1'b0;
    endtask

    // Issue one request at cycle 0 and score timing/result against the queue.
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [1:0] rw, input logic [1:0] ww,
                          input logic [31:0] addr, input logic [31:0] wd, input exp_t e);
        int          done_cyc, re_cyc, we_cyc, stall_low;
        logic [31:0] wdata_seen, addr_seen;
        logic        stall_done, mis_seen;
        exp_t        x;
        sb_q.push_back(e);
        R_Enable = rd; W_Enable = wr; R_Width = rw; W_Width = ww;
        Address = addr; WriteData = wd;
        done_cyc = -1; re_cyc = -1; we_cyc = -1; stall_low = 0;
        wdata_seen = 32'd0; addr_seen = 32'd0; stall_done = 1'b1; mis_seen = 1'b0;
        #1;
        if (!Stall) stall_low++;
        for (int c = 1; c <= 20; c++) begin
            @(posedge Clk); #1;
            if (c == 1) begin
                R_Enable = 1'b0; W_Enable = 1'b0;
            end
            if (Mem_RE && re_cyc < 0) begin
                re_cyc = c; addr_seen = 32'(Mem_Addr);
            end
            if (Mem_WE && we_cyc < 0) begin
                we_cyc = c; wdata_seen = Mem_WData; addr_seen = 32'(Mem_Addr);
            end
            if (Done) begin
                done_cyc = c; stall_done = Stall; mis_seen = Misaligned;
                break;
            end
            if (!Stall) stall_low++;
        end
        x = sb_q.pop_front();
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(x.done_cyc));
        check({tag, " re_cycle"},   32'(re_cyc),   32'(x.re_cyc));
        check({tag, " we_cycle"},   32'(we_cyc),   32'(x.we_cyc));
        if (x.we_cyc >= 0) check({tag, " wdata"}, wdata_seen, x.wdata);
        if (x.re_cyc >= 0 || x.we_cyc >= 0)
            check({tag, " mem_addr"}, addr_seen, 32'(addr[AW+1:2]));
        check({tag, " read_data"},  ReadData, x.rdata);
        check({tag, " misaligned"}, 32'(mis_seen), 32'(x.mis));
        check({tag, " stall_in_done"}, 32'(stall_done), 32'd0);
        check({tag, " stall_low_before_done"}, 32'(stall_low), 32'd0);
        @(posedge Clk); #1;
    endtask

    initial begin
        int we_cnt;
        Reset = 1'b1; R_Enable = 1'b0; W_Enable = 1'b0;
        R_Width = 2'd0; W_Width = 2'd0; Address = 32'd0; WriteData = 32'd0;
        bk_we = 1'b0; bk_addr = '0; bk_data = 32'd0;
        @(posedge Clk); #1;
        poke(10'd4, 32'h12345678);
        poke(10'd1, 32'h80FF7F01);
        poke(10'd2, 32'hAABBCCDD);
        poke(10'd0, 32'h00000000);
        check("rst read_data", ReadData, 32'd0);
        check("rst done",      32'(Done), 32'd0);
        check("rst misaligned",32'(Misaligned), 32'd0);
        check("rst mem_re",    32'(Mem_RE), 32'd0);
        check("rst mem_we",    32'(Mem_WE), 32'd0);
        check("rst mem_addr",  32'(Mem_Addr), 32'd0);
        check("rst mem_wdata", Mem_WData, 32'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("idle stall", 32'(Stall), 32'd0);

        run_op("lw_0x10",  1, 0, 2'd0, 2'd0, 32'h10, 32'd0, mk(3, 1, -1, 32'd0, 32'h12345678, 0));
        run_op("lrsvd",    1, 0, 2'd3, 2'd0, 32'h10, 32'd0, mk(1, -1, -1, 32'd0, 32'd0, 0));
        run_op("lb_0x7",   1, 0, 2'd2, 2'd0, 32'h7,  32'd0, mk(3, 1, -1, 32'd0, 32'hFFFFFF80, 0));
        run_op("lb_0x4",   1, 0, 2'd2, 2'd0, 32'h4,  32'd0, mk(3, 1, -1, 32'd0, 32'h00000001, 0));
        run_op("lh_0x6",   1, 0, 2'd1, 2'd0, 32'h6,  32'd0, mk(3, 1, -1, 32'd0, 32'hFFFF80FF, 0));
        run_op("lh_0x4",   1, 0, 2'd1, 2'd0, 32'h4,  32'd0, mk(3, 1, -1, 32'd0, 32'h00007F01, 0));
        run_op("lb_0x5",   1, 0, 2'd2, 2'd0, 32'h5,  32'd0, mk(3, 1, -1, 32'd0, 32'h0000007F, 0));

        run_op("sb_0x9",   0, 1, 2'd0, 2'd2, 32'h9,  32'hFFFFFF11, mk(4, 1, 3, 32'hAABB11DD, 32'h7F, 0));
        check("sb_0x9 sram", mem[2], 32'hAABB11DD);
        poke(10'd2, 32'hAABBCCDD);
        run_op("sh_0xA",   0, 1, 2'd0, 2'd1, 32'hA,  32'h99992233, mk(4, 1, 3, 32'h2233CCDD, 32'h7F, 0));
        check("sh_0xA sram", mem[2], 32'h2233CCDD);
        run_op("srsvd",    0, 1, 2'd0, 2'd3, 32'h8,  32'h01020304, mk(1, -1, -1, 32'd0, 32'h7F, 0));
        check("srsvd sram", mem[2], 32'h2233CCDD);
        run_op("sw_both",  1, 1, 2'd2, 2'd0, 32'h0,  32'hDEADBEEF, mk(2, -1, 1, 32'hDEADBEEF, 32'h7F, 0));
        check("sw_both sram", mem[0], 32'hDEADBEEF);

`ifdef MISALIGN_TRAP_EN
        run_op("lw_0x2",   1, 0, 2'd0, 2'd0, 32'h2,  32'd0, mk(1, -1, -1, 32'd0, 32'h7F, 1));
`else
        run_op("lw_0x2",   1, 0, 2'd0, 2'd0, 32'h2,  32'd0, mk(3, 1, -1, 32'd0, 32'hDEADBEEF, 0));
`endif

        // Reset while a sub-word store sits in WAIT.
        we_cnt = 0;
        W_Enable = 1'b1; W_Width = 2'd2; Address = 32'h9; WriteData = 32'h55;
        @(posedge Clk); #1;
        W_Enable = 1'b0;
        @(posedge Clk); #1;
        check("rst_mid stall_in_wait", 32'(Stall), 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        if (Mem_WE) we_cnt++;
        check("rst_mid stall", 32'(Stall), 32'd0);
        check("rst_mid read_data", ReadData, 32'd0);
        check("rst_mid done", 32'(Done), 32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            if (Mem_WE) we_cnt++;
        end
        check("rst_mid we_count", 32'(we_cnt), 32'd0);
        check("rst_mid sram", mem[2], 32'h2233CCDD);
        check("rst_mid idle_stall", 32'(Stall), 32'd0);
        check("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
